// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: 32-cycle radix-2 shift-add multiply and restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic        op_div;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        accept;
  logic        div_zero;
  logic        fast_mul;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        sgn_op;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] acc_nx;
  logic [63:0] mul_res;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Handshake: an operation is accepted in the IDLE cycle where start=1 and flush=0;
  // done pulses exactly once per accepted operation unless flush or rst abandons it.
  assign accept   = (state == IDLE) && start && !flush;
  assign sgn_op   = !op[0];
  assign div_zero = op[1] && (b == 32'd0);
  assign abs_a    = (sgn_op && a[31]) ? (32'd0 - a) : a;
  assign abs_b    = (sgn_op && b[31]) ? (32'd0 - b) : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  logic [63:0] sext_a;
  logic [63:0] sext_b;
  assign fast_mul = !op[1];
  assign sext_a   = {{32{sgn_op & a[31]}}, a};
  assign sext_b   = {{32{sgn_op & b[31]}}, b};
  assign fast_prod = sext_a * sext_b;
`else
  assign fast_mul = 1'b0;
`endif

  // acc holds {partial product} for multiply and {remainder, quotient} for divide
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = acc[63:31];
  assign div_diff  = div_shift - {1'b0, opnd};

  always_comb begin
    acc_nx = acc;
    if (state == MUL) begin
      acc_nx = {mul_sum, acc[31:1]};
    end else if (state == DIV) begin
      if (!div_diff[32]) acc_nx = {div_diff[31:0], acc[30:0], 1'b1};
      else               acc_nx = {div_shift[31:0], acc[30:0], 1'b0};
    end
  end

  assign mul_res = neg_q ? (64'd0 - acc) : acc;
  assign quo     = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem     = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
  assign res_hi  = op_div ? rem : mul_res[63:32];
  assign res_lo  = op_div ? quo : mul_res[31:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op[1])         state_nx = div_zero ? DONE : DIV;
          else if (fast_mul) state_nx = DONE;
          else               state_nx = MUL;
        end
      end
      MUL, DIV: begin
        if (flush)               state_nx = IDLE;
        else if (cnt == 6'd31)   state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            op_div <= op[1];
            cnt    <= 6'd0;
            if (op[1]) begin
              opnd  <= abs_b;
              // divide by zero bypasses iteration: remainder slot carries a, quotient all ones
              acc   <= div_zero ? {a, 32'hFFFF_FFFF} : {32'd0, abs_a};
              neg_q <= !div_zero && sgn_op && (a[31] ^ b[31]);
              neg_r <= !div_zero && sgn_op && a[31];
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc   <= fast_prod;
              neg_q <= 1'b0;
`else
              opnd  <= abs_a;
              acc   <= {32'd0, abs_b};
              neg_q <= sgn_op && (a[31] ^ b[31]);
`endif
              neg_r <= 1'b0;
            end
          end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        MUL, DIV: begin
          if (!flush) begin
            acc <= acc_nx;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (!flush) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == MUL) || (state == DIV);
  assign stall     = accept || busy;
  assign done      = (state == DONE) && !flush && !rst;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign state_dbg = state;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: requests a multiply or divide; sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have the ports a and b, input, 32 bits each: operands (dividend a, divisor b), captured when start is accepted.
REQ-006 The block SHALL have the port flush, input, 1 bit: aborts the operation in progress.
REQ-007 The block SHALL have the ports hi_we and lo_we, input, 1 bit each: MTHI/MTLO write enables.
REQ-008 The block SHALL have the port wdata, input, 32 bits: MTHI/MTLO write data.
REQ-009 The block SHALL have the port busy, output, 1 bit: high in MUL or DIV state.
REQ-010 The block SHALL have the port stall, output, 1 bit: pipeline hold request.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have the ports hi and lo, output, 32 bits each: HI/LO architectural registers.

Function
REQ-013 States SHALL be exactly IDLE, MUL, DIV and DONE.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL latch a, b and op, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-015 MUL and DIV SHALL run exactly 32 iteration cycles, counted by a 6-bit counter, then enter DONE.
REQ-016 Multiply SHALL be radix-2 shift-add on magnitudes, giving a 64-bit product {hi,lo}; MULT negates the product when a[31]^b[31].
REQ-017 Divide SHALL be radix-2 restoring on magnitudes; lo=quotient, hi=remainder.
REQ-018 DIV sign rules: quotient negative iff a[31]^b[31]; remainder takes the sign of a.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no flag).
REQ-020 Divide by zero (b=0, DIV or DIVU) SHALL skip iteration and go to DONE on the next cycle, with lo=0xFFFFFFFF and hi=a.
REQ-021 In DONE, hi/lo SHALL be written with the result, done=1 for that one cycle, and the next state SHALL be IDLE.
REQ-022 Iterative latency: done SHALL be high in the 33rd cycle after the accept cycle.
REQ-023 stall SHALL equal (IDLE & start & ~flush) | MUL | DIV; stall SHALL be 0 in DONE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 flush in MUL/DIV/DONE SHALL force IDLE on the next edge, leave hi/lo unchanged and suppress done.
REQ-026 flush together with start in IDLE SHALL win: the operation is not accepted.
REQ-027 hi_we/lo_we SHALL update hi/lo only in IDLE when no start is being accepted; otherwise they are ignored.
REQ-028 hi_we/lo_we SHALL NOT be honored while busy.

Reset
REQ-029 When rst=1 at an edge, the block SHALL enter IDLE and clear hi, lo and the counter to 0.
REQ-030 After reset, busy, stall and done SHALL be 0, with rst taking priority over all inputs.
REQ-031 Reset mid-operation SHALL abandon the operation without producing a done pulse.

Configuration
REQ-032 The macro MULDIV_FAST_MUL_EN SHALL control the multiply path.
REQ-033 With MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL compute the product with a single-cycle multiplier and go IDLE->DONE, so done is high in the cycle after accept and stall is high for the accept cycle only.
REQ-034 Without MULDIV_FAST_MUL_EN, multiply SHALL follow REQ-015/REQ-016; divide behaviour SHALL be identical in both builds.

Verification
REQ-035 The bench SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> done at cycle 33 (1 if fast), hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 The bench SHALL cover: MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 The bench SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU a=100, b=0 -> done 1 cycle after accept, lo=0xFFFFFFFF, hi=100.
REQ-038 The bench SHALL cover: DIVU started, flush at iteration 10 -> IDLE next cycle, no done pulse, hi/lo keep prior values; a new start is accepted on the following cycle.
REQ-039 The bench SHALL cover: hi_we=1, wdata=0x12345678 in IDLE -> hi=0x12345678; the same write asserted while busy -> hi unchanged.
REQ-040 The bench SHALL cover: rst asserted at DIV iteration 20 -> IDLE, hi=lo=0, busy=0, no done.
